// File: rtl/prim_fifo_wr_arb_if.sv
// Write-side bundle between NumReq requesters, the arbiter and one FIFO write port.
// The arbiter takes the slave view; the requesters plus FIFO environment take the master view.
interface prim_fifo_wr_arb_if #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned Width  = 16
);
   localparam int unsigned IdxW = $clog2(NumReq);

   logic [NumReq-1:0]       req_valid;
   logic [NumReq-1:0]       req_ready;
   logic [NumReq*Width-1:0] req_data;
   logic                    fifo_wvalid;
   logic                    fifo_wready;
   logic [Width-1:0]        fifo_wdata;
   logic [IdxW-1:0]         fifo_wsrc;

   modport master (
      output req_valid, req_data, fifo_wready,
      input  req_ready, fifo_wvalid, fifo_wdata, fifo_wsrc
   );

   modport slave (
      input  req_valid, req_data, fifo_wready,
      output req_ready, fifo_wvalid, fifo_wdata, fifo_wsrc
   );
endinterface

// File: rtl/prim_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NumReq sources, with per-source
// resident-entry counts fed back from pops and an optional per-source quota.
module prim_fifo_wr_arb #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned Width  = 16,
   parameter int unsigned Quota  = 2,
   localparam int unsigned IdxW  = $clog2(NumReq),
   localparam int unsigned CntW  = (Quota == 0) ? 8 : $clog2(Quota + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clr_i,
   prim_fifo_wr_arb_if.slave      bus_io,
   input  logic                   pop_i,
   input  logic [IdxW-1:0]        pop_src_i,
   output logic [NumReq-1:0]      quota_full_o,
   output logic                   err_o
);
   typedef enum logic {StUnlocked, StLocked} state_e;

   localparam logic [CntW-1:0] QuotaC = CntW'(Quota);
   localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_q, rr_d, held_q, held_d;
   logic [CntW-1:0]   cnt_q [NumReq];
   logic [CntW-1:0]   cnt_d [NumReq];
   logic              err_q, err_d;

   logic [Width-1:0]  data_arr [NumReq];
   logic [NumReq-1:0] at_quota, eligible, pop_hit, valid_pop, inc, req_ready;
   logic [IdxW-1:0]   pick, grant;
   logic              found, clearing, wvalid, accept;
   int unsigned       scan;

   assign clearing = ~rst_ni | clr_i;

   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         data_arr[i] = bus_io.req_data[i*Width +: Width];
         at_quota[i] = (Quota != 0) && (cnt_q[i] == QuotaC);
         pop_hit[i]  = pop_i && (pop_src_i == IdxW'(i));
      end
   end

   assign eligible = bus_io.req_valid & ~at_quota;

   // First eligible index at or after rr_q, wrapping; rr_q < NumReq so one subtract suffices.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      scan  = 0;
      for (int unsigned off = 0; off < NumReq; off++) begin
         scan = 32'(rr_q) + off;
         if (scan >= NumReq) scan = scan - NumReq;
         if (!found && eligible[IdxW'(scan)]) begin
            found = 1'b1;
            pick  = IdxW'(scan);
         end
      end
   end

   always_comb begin
      grant = (state_q == StLocked) ? held_q : pick;
      if (clearing) begin
         wvalid = 1'b0;
      end else if (state_q == StLocked) begin
         wvalid = bus_io.req_valid[held_q];
      end else begin
         wvalid = |eligible;
      end
      accept    = wvalid & bus_io.fifo_wready;
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   assign bus_io.fifo_wvalid = wvalid;
   assign bus_io.fifo_wsrc   = wvalid ? grant : '0;
   assign bus_io.fifo_wdata  = wvalid ? data_arr[grant] : '0;
   assign bus_io.req_ready   = req_ready;
   assign quota_full_o       = at_quota;
   assign err_o              = err_q;

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      rr_d    = rr_q;
      if (accept) begin
         rr_d    = (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
         state_d = StUnlocked;
      end else if (state_q == StUnlocked && wvalid) begin
         state_d = StLocked;
         held_d  = grant;
      end else if (state_q == StLocked && !bus_io.req_valid[held_q]) begin
         // Requester withdrew mid-transfer; rearbitrate next cycle.
         state_d = StUnlocked;
      end
   end

   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         valid_pop[i] = pop_hit[i] && (cnt_q[i] != '0);
         inc[i]       = accept && (grant == IdxW'(i));
         cnt_d[i]     = cnt_q[i];
         if (inc[i] && !valid_pop[i] && cnt_q[i] != CntMax) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (!inc[i] && valid_pop[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
      // Covers both an empty source and a tag outside 0..NumReq-1.
      err_d = pop_i && !(|valid_pop);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_i) begin
         state_q <= StUnlocked;
         rr_q    <= '0;
         held_q  <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         held_q  <= held_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_prim_fifo_wr_arb.sv
// Directed bench for prim_fifo_wr_arb: unlimited-quota, quota-2 and three-requester instances.
module tb_prim_fifo_wr_arb;
   logic       clk = 1'b0;
   logic       rst_n, clr, pop;
   logic [1:0] pop_src;
   logic [3:0] qf0, qf2;
   logic [2:0] qf3;
   logic       err0, err2, err3;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   prim_fifo_wr_arb_if #(.NumReq(4), .Width(16)) if0 ();
   prim_fifo_wr_arb_if #(.NumReq(4), .Width(16)) if2 ();
   prim_fifo_wr_arb_if #(.NumReq(3), .Width(16)) if3 ();

   prim_fifo_wr_arb #(.NumReq(4), .Width(16), .Quota(0)) u_q0 (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus_io(if0), .pop_i(pop),
      .pop_src_i(pop_src), .quota_full_o(qf0), .err_o(err0)
   );
   prim_fifo_wr_arb #(.NumReq(4), .Width(16), .Quota(2)) u_q2 (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus_io(if2), .pop_i(pop),
      .pop_src_i(pop_src), .quota_full_o(qf2), .err_o(err2)
   );
   prim_fifo_wr_arb #(.NumReq(3), .Width(16), .Quota(2)) u_n3 (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus_io(if3), .pop_i(pop),
      .pop_src_i(pop_src), .quota_full_o(qf3), .err_o(err3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      if0.req_valid = '0; if0.fifo_wready = 1'b0;
      if0.req_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      if2.req_valid = '0; if2.fifo_wready = 1'b0;
      if2.req_data  = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
      if3.req_valid = '0; if3.fifo_wready = 1'b0;
      if3.req_data  = {16'hC002, 16'hC001, 16'hC000};
      clr = 1'b0; pop = 1'b0; pop_src = '0;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      do_reset;
      #1;
      n_tests++;
      if (if2.fifo_wvalid !== 1'b0) begin
         n_fail++; $display("FAIL reset_wvalid: got %b want 0", if2.fifo_wvalid);
      end
      n_tests++;
      if (if2.req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0000", if2.req_ready);
      end
      n_tests++;
      if (if2.fifo_wsrc !== 2'd0 || if2.fifo_wdata !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_src_data: got %0d/%h want 0/0000", if2.fifo_wsrc, if2.fifo_wdata);
      end
      n_tests++;
      if (qf2 !== 4'b0000 || err2 !== 1'b0) begin
         n_fail++; $display("FAIL reset_qf_err: got %b/%b want 0000/0", qf2, err2);
      end
      if2.req_valid = 4'b0010;
      #1;
      n_tests++;
      if (if2.fifo_wvalid !== 1'b1 || if2.fifo_wsrc !== 2'd1 || if2.fifo_wdata !== 16'hB001) begin
         n_fail++;
         $display("FAIL reset_comb_grant: got v=%b src=%0d data=%h want 1/1/b001",
                  if2.fifo_wvalid, if2.fifo_wsrc, if2.fifo_wdata);
      end
      n_tests++;
      if (if2.req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_noready_wready0: got %b want 0000", if2.req_ready);
      end
   endtask

   task automatic test_round_robin;
      do_reset;
      if0.req_valid   = 4'hF;
      if0.fifo_wready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         n_tests++;
         if (if0.fifo_wvalid !== 1'b1 || if0.fifo_wsrc !== 2'(k % 4) ||
             if0.fifo_wdata !== 16'hA000 + 16'(k % 4) || if0.req_ready !== 4'(1 << (k % 4))) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got v=%b src=%0d data=%h rdy=%b want 1/%0d/%h/%b", k,
                     if0.fifo_wvalid, if0.fifo_wsrc, if0.fifo_wdata, if0.req_ready, k % 4,
                     16'hA000 + 16'(k % 4), 4'(1 << (k % 4)));
         end
         tick;
      end
   endtask

   task automatic test_lock;
      do_reset;
      // Accept req 2 alone so the pointer sits at 3.
      if0.req_valid   = 4'b0100;
      if0.fifo_wready = 1'b1;
      tick;
      if0.req_valid   = 4'b0010;
      if0.fifo_wready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (if0.fifo_wsrc !== 2'd1 || if0.fifo_wdata !== 16'hA001 || if0.req_ready !== 4'b0000 ||
             if0.fifo_wvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_hold%0d: got src=%0d data=%h rdy=%b want 1/a001/0000", c,
                     if0.fifo_wsrc, if0.fifo_wdata, if0.req_ready);
         end
         tick;
         if0.req_valid = 4'b0011;
      end
      if0.fifo_wready = 1'b1;
      #1;
      n_tests++;
      if (if0.fifo_wsrc !== 2'd1 || if0.req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL lock_accept: got src=%0d rdy=%b want 1/0010", if0.fifo_wsrc, if0.req_ready);
      end
      tick;
      #1;
      n_tests++;
      if (if0.fifo_wsrc !== 2'd0 || if0.req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL lock_next: got src=%0d rdy=%b want 0/0001", if0.fifo_wsrc, if0.req_ready);
      end
      tick;
   endtask

   task automatic test_quota;
      do_reset;
      if2.req_valid   = 4'b0001;
      if2.fifo_wready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_tests++;
         if (if2.req_ready !== 4'b0001 || qf2 !== 4'b0000) begin
            n_fail++;
            $display("FAIL quota_accept%0d: got rdy=%b qf=%b want 0001/0000", c, if2.req_ready, qf2);
         end
         tick;
      end
      #1;
      n_tests++;
      if (qf2 !== 4'b0001 || if2.fifo_wvalid !== 1'b0 || if2.req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL quota_full: got qf=%b v=%b rdy=%b want 0001/0/0000", qf2,
                  if2.fifo_wvalid, if2.req_ready);
      end
      pop = 1'b1; pop_src = 2'd0;
      tick;
      pop = 1'b0;
      #1;
      n_tests++;
      if (qf2 !== 4'b0000 || if2.req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL quota_after_pop: got qf=%b rdy=%b want 0000/0001", qf2, if2.req_ready);
      end
      tick;
      #1;
      n_tests++;
      if (qf2 !== 4'b0001 || if2.fifo_wvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL quota_refull: got qf=%b v=%b want 0001/0", qf2, if2.fifo_wvalid);
      end
   endtask

   task automatic test_same_cycle;
      do_reset;
      if2.req_valid   = 4'b0100;
      if2.fifo_wready = 1'b1;
      tick;
      pop = 1'b1; pop_src = 2'd2;
      #1;
      n_tests++;
      if (if2.req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL same_accept: got rdy=%b want 0100", if2.req_ready);
      end
      tick;
      pop = 1'b0;
      #1;
      n_tests++;
      if (qf2 !== 4'b0000 || err2 !== 1'b0 || if2.req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL same_count1: got qf=%b err=%b rdy=%b want 0000/0/0100", qf2, err2,
                  if2.req_ready);
      end
      tick;
      #1;
      n_tests++;
      if (qf2 !== 4'b0100 || if2.fifo_wvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL same_count2: got qf=%b v=%b want 0100/0", qf2, if2.fifo_wvalid);
      end
   endtask

   task automatic test_err;
      do_reset;
      if3.req_valid   = 3'b100;
      if3.fifo_wready = 1'b1;
      tick;
      if3.req_valid = 3'b000;
      // Tag 3: empty source on the 4-way block, out of range on the 3-way block.
      pop = 1'b1; pop_src = 2'd3;
      #1;
      n_tests++;
      if (err2 !== 1'b0 || err3 !== 1'b0) begin
         n_fail++; $display("FAIL err_not_early: got %b/%b want 0/0", err2, err3);
      end
      tick;
      pop = 1'b0;
      #1;
      n_tests++;
      if (err2 !== 1'b1 || err3 !== 1'b1 || qf2 !== 4'b0000) begin
         n_fail++; $display("FAIL err_pulse: got %b/%b qf=%b want 1/1/0000", err2, err3, qf2);
      end
      tick;
      n_tests++;
      if (err2 !== 1'b0 || err3 !== 1'b0) begin
         n_fail++; $display("FAIL err_one_cycle: got %b/%b want 0/0", err2, err3);
      end
      pop = 1'b1; pop_src = 2'd2;
      tick;
      pop = 1'b0;
      #1;
      n_tests++;
      if (err3 !== 1'b0 || err2 !== 1'b1) begin
         n_fail++; $display("FAIL err_valid_pop: got n3=%b q2=%b want 0/1", err3, err2);
      end
      if2.req_valid   = 4'b1000;
      if2.fifo_wready = 1'b1;
      tick;
      n_tests++;
      if (qf2 !== 4'b0000) begin
         n_fail++; $display("FAIL err_cnt3_zero: got qf=%b want 0000", qf2);
      end
      tick;
      n_tests++;
      if (qf2 !== 4'b1000) begin
         n_fail++; $display("FAIL err_cnt3_two: got qf=%b want 1000", qf2);
      end
   endtask

   task automatic test_clear(input bit use_rst);
      do_reset;
      if2.req_valid   = 4'b0001;
      if2.fifo_wready = 1'b1;
      tick;
      tick;
      if2.req_valid   = 4'b1000;
      if2.fifo_wready = 1'b0;
      #1;
      n_tests++;
      if (if2.fifo_wsrc !== 2'd3 || qf2 !== 4'b0001) begin
         n_fail++;
         $display("FAIL clear%0d_setup: got src=%0d qf=%b want 3/0001", use_rst, if2.fifo_wsrc, qf2);
      end
      tick;
      if2.req_valid = 4'b1001;
      tick;
      if (use_rst) rst_n = 1'b0;
      else clr = 1'b1;
      if2.fifo_wready = 1'b1;
      #1;
      n_tests++;
      if (if2.req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL clear%0d_drop: got rdy=%b want 0000", use_rst, if2.req_ready);
      end
      tick;
      rst_n = 1'b1; clr = 1'b0;
      if2.req_valid = 4'b1111;
      #1;
      n_tests++;
      if (if2.fifo_wsrc !== 2'd0 || if2.req_ready !== 4'b0001 || qf2 !== 4'b0000) begin
         n_fail++;
         $display("FAIL clear%0d_state: got src=%0d rdy=%b qf=%b want 0/0001/0000", use_rst,
                  if2.fifo_wsrc, if2.req_ready, qf2);
      end
      tick;
      #1;
      n_tests++;
      if (if2.fifo_wsrc !== 2'd1 || qf2 !== 4'b0000) begin
         n_fail++;
         $display("FAIL clear%0d_next: got src=%0d qf=%b want 1/0000", use_rst, if2.fifo_wsrc, qf2);
      end
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_lock;
      test_quota;
      test_same_cycle;
      test_err;
      test_clear(1'b0);
      test_clear(1'b1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
